// File: rtl/mat_mul_pkg.sv
// rtl/mat_mul_pkg.sv - shared types, constants and helpers for mat_mul and its scheduler
//
// Purpose : default dimensions, a constant clog2 helper (pipeline depth and field
//           widths), matrix/id typedefs at the default dimensions, and the
//           scheduler state enum.
// Ports   : none (package)
package mat_mul_pkg;

  localparam int N_DEF     = 2;
  localparam int W_IN_DEF  = 8;
  localparam int W_OUT_DEF = 32;
  localparam int NREQ_DEF  = 2;

  // ceil(log2(v)); 0 for v <= 1
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Number of adder-tree register stages behind the operand register
  function automatic int depth(input int n);
    return clog2(n);
  endfunction

  typedef logic [N_DEF-1:0][N_DEF-1:0][W_IN_DEF-1:0]  matrix_in_t;
  typedef logic [N_DEF-1:0][N_DEF-1:0][W_OUT_DEF-1:0] matrix_out_t;
  typedef logic [clog2(NREQ_DEF)-1:0]                 id_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mat_mul.sv
// rtl/mat_mul.sv - signed NxN matrix multiply with clog2(N)-stage pipelined adder tree
//
// Purpose : products are formed combinationally from the (externally registered)
//           operands; each register stage halves the number of partial sums per
//           output element. All stages advance only while cen=1. No reset: the
//           owner masks stale sums with its own valid bits.
// Ports   : clk            clock
//           cen            clock enable for every stage
//           matrix_1/2     packed [N][N][W_IN] signed operands
//           result         packed [N][N][W_OUT] signed result, clog2(N) cycles later
module mat_mul
  import mat_mul_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W_IN  = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF
) (
  input  logic                   clk,
  input  logic                   cen,
  input  logic [N*N*W_IN-1:0]    matrix_1,
  input  logic [N*N*W_IN-1:0]    matrix_2,
  output logic [N*N*W_OUT-1:0]   result
);

  localparam int DEPTH = depth(N);
  localparam int HALF  = N / 2;

  // src[s]: inputs to tree stage s; stg[s]: registered outputs of stage s
  logic signed [W_OUT-1:0] src [DEPTH][N][N][N];
  logic signed [W_OUT-1:0] stg [DEPTH][N][N][HALF];

  logic signed [W_IN-1:0]   a;
  logic signed [W_IN-1:0]   b;
  logic signed [2*W_IN-1:0] p;

  always_comb begin
    a = '0;
    b = '0;
    p = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < N; k++) begin
          a = matrix_1[(i*N+k)*W_IN +: W_IN];
          b = matrix_2[(k*N+j)*W_IN +: W_IN];
          p = a * b;
          src[0][i][j][k] = W_OUT'(p);
        end
      end
    end
    for (int s = 1; s < DEPTH; s++) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          for (int t = 0; t < N; t++) src[s][i][j][t] = '0;
          for (int t = 0; t < HALF; t++) src[s][i][j][t] = stg[s-1][i][j][t];
        end
      end
    end
  end

  // Stage s keeps N>>(s+1) live partial sums; the rest are parked at zero.
  always_ff @(posedge clk) begin
    if (cen) begin
      for (int s = 0; s < DEPTH; s++) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            for (int t = 0; t < HALF; t++) begin
              if (t < (N >> (s + 1))) begin
                stg[s][i][j][t] <= src[s][i][j][2*t] + src[s][i][j][2*t+1];
              end else begin
                stg[s][i][j][t] <= '0;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    result = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        result[(i*N+j)*W_OUT +: W_OUT] = stg[DEPTH-1][i][j][0];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with internal rotating pointer
//
// Purpose : grants the first asserted request at or after the pointer. The pointer
//           moves to grant+1 (mod NREQ) only when advance is high.
// Ports   : clk, rstn      clock, async active-low reset (pointer -> 0)
//           req[NREQ]      request vector (already qualified by the caller)
//           advance        grant was consumed this cycle
//           gnt_onehot     one-hot grant, zero when no request
//           gnt_idx        index of the grant
//           any            at least one request is granted
module rr_arbiter
  import mat_mul_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic                     advance,
  output logic [NREQ-1:0]          gnt_onehot,
  output logic [clog2(NREQ)-1:0]   gnt_idx,
  output logic                     any
);

  localparam int IDW = clog2(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  logic [IDW-1:0]    ptr;
  logic [2*NREQ-1:0] req2;
  logic [NREQ-1:0]   rot;
  logic              found;
  int                off;
  int                sum;

  // Rotate the request vector so that bit 0 is the requester at the pointer,
  // then take the lowest set bit and rotate the index back.
  always_comb begin
    req2  = {req, req} >> ptr;
    rot   = req2[NREQ-1:0];
    found = 1'b0;
    off   = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    gnt_idx    = sum[IDW-1:0];
    gnt_onehot = '0;
    for (int j = 0; j < NREQ; j++) begin
      gnt_onehot[j] = found && (sum == j);
    end
    any = found;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + IDW'(1);
    end
  end

endmodule

// File: rtl/mat_mul_sched.sv
// rtl/mat_mul_sched.sv - round-robin scheduler sharing one mat_mul pipeline between NREQ requesters
//
// Purpose : arbitrates operand pairs into the operand register (stage 0), carries
//           valid and requester id alongside the mat_mul adder tree, returns results
//           on a ready/valid port, and provides flush/drain control and occupancy.
// Ports   : clk, rstn              clock, async active-low reset
//           s_valid/s_ready        per-requester operand handshake (s_ready one-hot or 0)
//           s_matrix_1/2           packed [NREQ][N][N][W_IN] operands
//           mm_cen                 mat_mul clock enable (low only on output stall)
//           mm_matrix_1/2          registered operands to mat_mul
//           mm_result              mat_mul result
//           m_valid/m_ready        result handshake
//           m_result, m_id         result (pass-through) and requester index
//           flush_req/flush_done   drain request level / completion pulse
//           busy, occupancy        pipeline occupancy status
module mat_mul_sched
  import mat_mul_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W_IN  = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NREQ-1:0]                 s_valid,
  output logic [NREQ-1:0]                 s_ready,
  input  logic [NREQ*N*N*W_IN-1:0]        s_matrix_1,
  input  logic [NREQ*N*N*W_IN-1:0]        s_matrix_2,
  output logic                            mm_cen,
  output logic [N*N*W_IN-1:0]             mm_matrix_1,
  output logic [N*N*W_IN-1:0]             mm_matrix_2,
  input  logic [N*N*W_OUT-1:0]            mm_result,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [N*N*W_OUT-1:0]            m_result,
  output logic [clog2(NREQ)-1:0]          m_id,
  input  logic                            flush_req,
  output logic                            flush_done,
  output logic                            busy,
  output logic [clog2(depth(N)+2)-1:0]    occupancy
);

  localparam int DEPTH = depth(N);
  localparam int IDW   = clog2(NREQ);
  localparam int OCW   = clog2(DEPTH + 2);
  localparam int MW    = N * N * W_IN;

  sched_state_e   state;
  sched_state_e   state_nxt;
  logic           accept_en;
  logic           stall;
  logic           hs;
  logic           pop;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [DEPTH:0]  vld;
  logic [IDW-1:0]  id_q [DEPTH+1];

  // Only the result port can stall; bubbles keep flowing otherwise.
  assign stall  = vld[DEPTH] & ~m_ready;
  assign mm_cen = ~stall;
  assign pop    = vld[DEPTH] & m_ready;

  // Grant qualification: no accept while stalled, draining, or in the cycle
  // flush_req rises.
  assign arb_req = s_valid & {NREQ{accept_en & mm_cen}};

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk        (clk),
    .rstn       (rstn),
    .req        (arb_req),
    .advance    (gnt_any),
    .gnt_onehot (gnt),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign s_ready = gnt;
  assign hs      = gnt_any;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= (state == DRAIN) && (state_nxt == DONE);
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush_req)         state_nxt = DRAIN;
      DRAIN:   if (occupancy == '0)   state_nxt = DONE;
      DONE:    if (!flush_req)        state_nxt = RUN;
      default:                        state_nxt = RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    accept_en = (state == RUN) && !flush_req;
  end

  // ---------------- datapath side-band ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld         <= '0;
      mm_matrix_1 <= '0;
      mm_matrix_2 <= '0;
      for (int d = 0; d <= DEPTH; d++) id_q[d] <= '0;
    end else if (mm_cen) begin
      vld <= {vld[DEPTH-1:0], hs};
      if (hs) begin
        mm_matrix_1 <= s_matrix_1[gnt_idx*MW +: MW];
        mm_matrix_2 <= s_matrix_2[gnt_idx*MW +: MW];
        id_q[0]     <= gnt_idx;
      end
      for (int d = 1; d <= DEPTH; d++) id_q[d] <= id_q[d-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occupancy <= '0;
    end else begin
      case ({hs, pop})
        2'b10:   occupancy <= occupancy + OCW'(1);
        2'b01:   occupancy <= occupancy - OCW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign busy     = (occupancy != '0);
  assign m_valid  = vld[DEPTH];
  assign m_id     = id_q[DEPTH];
  assign m_result = mm_result;

endmodule
